alarm_ctrl: RTL and testbench

//  User-interface and sequencing controller for the digital alarm core.
//  - Turns pre-debounced button pulses into HH:MM edits.
//  - Drives the core's hourIn/minIn digits and ldTime/ldAlarm load strobes.
//  - Owns alarmOn.
//  - Runs the ring/snooze/stop sequence from the core's alarm output.
//  - Sits between the button front-end and the alarm core; one instance per clock.

---
 rtl/alarm_ctrl.sv | 204 ++++++++++++++++++++
 tb/tb_alarm_ctrl.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/alarm_ctrl.sv
// Button-driven HH:MM editor and ring/snooze/stop sequencer for the alarm core.
// Digits presented to the core are held in binary and converted to BCD on the way out.
module alarm_ctrl #(
  parameter int SNOOZE_MIN = 5,
  parameter int RING_CYC   = 600,
  parameter int RCW        = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btnMode,
  input  logic       btnSet,
  input  logic       btnInc,
  input  logic       btnSnooze,
  input  logic       btnStop,
  input  logic       alarm,
  input  logic [1:0] hourOut1,
  input  logic [3:0] hourOut0,
  input  logic [3:0] minOut1,
  input  logic [3:0] minOut0,
  output logic [1:0] hourIn1,
  output logic [3:0] hourIn0,
  output logic [3:0] minIn1,
  output logic [3:0] minIn0,
  output logic       ldTime,
  output logic       ldAlarm,
  output logic       alarmOn,
  output logic       buzzer,
  output logic [2:0] state
);

  typedef enum logic [2:0] {IDLE = 3'd0, EDIT_H = 3'd1, EDIT_M = 3'd2, LOAD = 3'd3, RING = 3'd4} stateT;
  typedef enum logic [1:0] {TGT_TIME, TGT_ALARM, TGT_SNOOZE, TGT_RESTORE} tgtT;

  localparam logic [6:0]     SNZ       = 7'(SNOOZE_MIN);
  localparam logic [RCW-1:0] RING_LAST = RCW'(RING_CYC - 1);

  function automatic logic [4:0] hourBin(input logic [1:0] t, input logic [3:0] u);
    return ({3'b0, t} << 3) + ({3'b0, t} << 1) + {1'b0, u};
  endfunction

  function automatic logic [5:0] minBin(input logic [3:0] t, input logic [3:0] u);
    return ({2'b0, t} << 3) + ({2'b0, t} << 1) + {2'b0, u};
  endfunction

  function automatic logic [1:0] hourTens(input logic [4:0] v);
    if (v >= 5'd20) return 2'd2;
    else if (v >= 5'd10) return 2'd1;
    else return 2'd0;
  endfunction

  function automatic logic [3:0] minTens(input logic [5:0] v);
    if (v >= 6'd50) return 4'd5;
    else if (v >= 6'd40) return 4'd4;
    else if (v >= 6'd30) return 4'd3;
    else if (v >= 6'd20) return 4'd2;
    else if (v >= 6'd10) return 4'd1;
    else return 4'd0;
  endfunction

  // Units digit is below ten, so modulo-16 arithmetic on the low nibble is exact.
  function automatic logic [3:0] hourUnits(input logic [4:0] v);
    logic [3:0] t;
    t = {2'b0, hourTens(v)};
    return v[3:0] - (t << 3) - (t << 1);
  endfunction

  function automatic logic [3:0] minUnits(input logic [5:0] v);
    logic [3:0] t;
    t = minTens(v);
    return v[3:0] - (t << 3) - (t << 1);
  endfunction

  stateT          curState, nextState;
  tgtT            tgt;
  logic [4:0]     editHour, almHour, ldHour, curHour, snzHour;
  logic [5:0]     editMin, almMin, ldMin, curMin, snzMin;
  logic [6:0]     snzSum;
  logic [RCW-1:0] ringCnt;
  logic           snoozed, alarmQ, alarmOnQ, ringStart, ringDone, ringEnd;

  assign curHour   = hourBin(hourOut1, hourOut0);
  assign curMin    = minBin(minOut1, minOut0);
  assign ringStart = alarm & ~alarmQ & alarmOnQ;
  assign ringDone  = (ringCnt == RING_LAST);
  assign ringEnd   = btnStop | (~btnSnooze & ringDone);
  assign snzSum    = {1'b0, curMin} + SNZ;

  always_comb begin
    snzMin  = snzSum[5:0];
    snzHour = curHour;
    if (snzSum >= 7'd60) begin
      snzMin  = 6'(snzSum - 7'd60);
      snzHour = (curHour == 5'd23) ? 5'd0 : curHour + 5'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) curState <= IDLE;
    else       curState <= nextState;
  end

  always_comb begin
    nextState = curState;
    case (curState)
      IDLE:   if (ringStart) nextState = RING;
              else if (btnMode || btnSet) nextState = EDIT_H;
      EDIT_H: if (btnMode) nextState = IDLE;
              else if (btnSet) nextState = EDIT_M;
      EDIT_M: if (btnMode) nextState = IDLE;
              else if (btnSet) nextState = LOAD;
      LOAD:   nextState = IDLE;
      RING:   if (ringEnd) nextState = snoozed ? LOAD : IDLE;
              else if (btnSnooze) nextState = LOAD;
      default: nextState = IDLE;
    endcase
  end

  // The edge that enters LOAD also latches the value and the alarm side effects,
  // so they are all visible together during the strobe cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      tgt      <= TGT_TIME;
      editHour <= '0;
      editMin  <= '0;
      almHour  <= '0;
      almMin   <= '0;
      ldHour   <= '0;
      ldMin    <= '0;
      ringCnt  <= '0;
      snoozed  <= 1'b0;
      alarmQ   <= 1'b0;
      alarmOnQ <= 1'b0;
    end else begin
      alarmQ <= alarm;
      case (curState)
        IDLE: begin
          if (ringStart) begin
            ringCnt <= '0;
          end else if (btnMode) begin
            tgt      <= TGT_TIME;
            editHour <= curHour;
            editMin  <= curMin;
          end else if (btnSet) begin
            tgt      <= TGT_ALARM;
            editHour <= almHour;
            editMin  <= almMin;
          end else if (btnStop) begin
            alarmOnQ <= ~alarmOnQ;
          end
        end
        EDIT_H: begin
          if (!btnMode && !btnSet && btnInc)
            editHour <= (editHour == 5'd23) ? 5'd0 : editHour + 5'd1;
        end
        EDIT_M: begin
          if (!btnMode) begin
            if (btnSet) begin
              ldHour <= editHour;
              ldMin  <= editMin;
              if (tgt == TGT_ALARM) begin
                almHour  <= editHour;
                almMin   <= editMin;
                alarmOnQ <= 1'b1;
              end
            end else if (btnInc) begin
              editMin <= (editMin == 6'd59) ? 6'd0 : editMin + 6'd1;
            end
          end
        end
        RING: begin
          ringCnt <= ringCnt + RCW'(1);
          if (ringEnd) begin
            if (snoozed) begin
              tgt     <= TGT_RESTORE;
              ldHour  <= almHour;
              ldMin   <= almMin;
              snoozed <= 1'b0;
            end
          end else if (btnSnooze) begin
            tgt     <= TGT_SNOOZE;
            ldHour  <= snzHour;
            ldMin   <= snzMin;
            snoozed <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    buzzer  = (curState == RING);
    ldTime  = (curState == LOAD) && (tgt == TGT_TIME);
    ldAlarm = (curState == LOAD) && (tgt != TGT_TIME);
    hourIn1 = hourTens(ldHour);
    hourIn0 = hourUnits(ldHour);
    minIn1  = minTens(ldMin);
    minIn0  = minUnits(ldMin);
  end

  assign alarmOn = alarmOnQ;
  assign state   = curState;

endmodule

// File: tb/tb_alarm_ctrl.sv
// Bench for alarm_ctrl: directed scenarios with literal expectations, then random
// button/alarm traffic compared every cycle against a minute-arithmetic model.
module tb_alarm_ctrl;

  localparam int RC = 24;
  localparam int SN = 5;

  localparam logic [4:0] B_MODE = 5'b00001;
  localparam logic [4:0] B_SET  = 5'b00010;
  localparam logic [4:0] B_INC  = 5'b00100;
  localparam logic [4:0] B_SNZ  = 5'b01000;
  localparam logic [4:0] B_STOP = 5'b10000;

  logic       clk, reset;
  logic       btnMode, btnSet, btnInc, btnSnooze, btnStop, alarm;
  logic [1:0] hourOut1, hourIn1;
  logic [3:0] hourOut0, minOut1, minOut0, hourIn0, minIn1, minIn0;
  logic       ldTime, ldAlarm, alarmOn, buzzer;
  logic [2:0] state;
  logic [20:0] dutVec;

  int checks = 0;
  int failures = 0;
  bit checkEn = 0;

  alarm_ctrl #(.SNOOZE_MIN(SN), .RING_CYC(RC), .RCW(5)) dut (
    .clk(clk), .reset(reset),
    .btnMode(btnMode), .btnSet(btnSet), .btnInc(btnInc),
    .btnSnooze(btnSnooze), .btnStop(btnStop), .alarm(alarm),
    .hourOut1(hourOut1), .hourOut0(hourOut0), .minOut1(minOut1), .minOut0(minOut0),
    .hourIn1(hourIn1), .hourIn0(hourIn0), .minIn1(minIn1), .minIn0(minIn0),
    .ldTime(ldTime), .ldAlarm(ldAlarm), .alarmOn(alarmOn), .buzzer(buzzer),
    .state(state)
  );

  assign dutVec = {state, ldTime, ldAlarm, alarmOn, buzzer, hourIn1, hourIn0, minIn1, minIn0};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: 0 idle, 1 edit hour, 2 edit minute, 3 load, 4 ring; targets 0 time, 1 alarm, 2 snooze, 3 restore.
  int mState, mTgt, mEditH, mEditM, mAlmH, mAlmM, mLdH, mLdM, mRingStart, cyc;
  bit mSnoozed, mAlarmQ, mOn;
  int curH, curM, tot;
  bit rise, timeout;

  always @(posedge clk) begin
    cyc++;
    if (reset) begin
      mState = 0; mTgt = 0; mEditH = 0; mEditM = 0; mAlmH = 0; mAlmM = 0;
      mLdH = 0; mLdM = 0; mSnoozed = 0; mAlarmQ = 0; mOn = 0;
    end else begin
      curH = int'(hourOut1) * 10 + int'(hourOut0);
      curM = int'(minOut1) * 10 + int'(minOut0);
      rise = alarm && !mAlarmQ && mOn;
      case (mState)
        0: begin
          if (rise) begin mState = 4; mRingStart = cyc; end
          else if (btnMode) begin mState = 1; mTgt = 0; mEditH = curH; mEditM = curM; end
          else if (btnSet) begin mState = 1; mTgt = 1; mEditH = mAlmH; mEditM = mAlmM; end
          else if (btnStop) mOn = !mOn;
        end
        1: begin
          if (btnMode) mState = 0;
          else if (btnSet) mState = 2;
          else if (btnInc) mEditH = (mEditH + 1) % 24;
        end
        2: begin
          if (btnMode) mState = 0;
          else if (btnSet) begin
            mState = 3; mLdH = mEditH; mLdM = mEditM;
            if (mTgt == 1) begin mAlmH = mEditH; mAlmM = mEditM; mOn = 1; end
          end else if (btnInc) mEditM = (mEditM + 1) % 60;
        end
        3: mState = 0;
        default: begin
          timeout = (cyc - mRingStart) == RC;
          if (btnStop || (!btnSnooze && timeout)) begin
            if (mSnoozed) begin
              mState = 3; mTgt = 3; mLdH = mAlmH; mLdM = mAlmM; mSnoozed = 0;
            end else mState = 0;
          end else if (btnSnooze) begin
            tot = curH * 60 + curM + SN;
            mLdH = (tot / 60) % 24; mLdM = tot % 60;
            mTgt = 2; mSnoozed = 1; mState = 3;
          end
        end
      endcase
      mAlarmQ = alarm;
    end
  end

  function automatic logic [20:0] packVec(input logic [2:0] st, input logic lt, input logic la,
                                          input logic on, input logic bz, input logic [1:0] h1,
                                          input logic [3:0] h0, input logic [3:0] m1, input logic [3:0] m0);
    return {st, lt, la, on, bz, h1, h0, m1, m0};
  endfunction

  function automatic logic [20:0] modelVec();
    return packVec(3'(mState), mState == 3 && mTgt == 0, mState == 3 && mTgt != 0, mOn, mState == 4,
                   2'(mLdH / 10), 4'(mLdH % 10), 4'(mLdM / 10), 4'(mLdM % 10));
  endfunction

  task automatic checkOutput(input string name, input logic [20:0] act, input logic [20:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) if (checkEn) checkOutput("cycle", dutVec, modelVec());

  task automatic applyStimulus(input logic [4:0] b);
    {btnStop, btnSnooze, btnInc, btnSet, btnMode} = b;
    @(posedge clk); #1;
    {btnStop, btnSnooze, btnInc, btnSet, btnMode} = 5'b0;
  endtask

  task automatic press(input logic [4:0] b, input int n);
    repeat (n) applyStimulus(b);
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic setTime(input int h, input int m);
    hourOut1 = 2'(h / 10); hourOut0 = 4'(h % 10);
    minOut1 = 4'(m / 10);  minOut0 = 4'(m % 10);
  endtask

  int ringLen;

  initial begin
    reset = 1'b1; alarm = 1'b0;
    {btnStop, btnSnooze, btnInc, btnSet, btnMode} = 5'b0;
    setTime(0, 0);
    tick(2);
    checkEn = 1;
    reset = 1'b0;
    checkOutput("resetVec", dutVec, 21'd0);

    // Time set to 12:22
    applyStimulus(B_MODE); press(B_INC, 12); applyStimulus(B_SET); press(B_INC, 22); applyStimulus(B_SET);
    checkOutput("t1Load", dutVec, packVec(3'd3, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 4'd2, 4'd2, 4'd2));
    tick(1);
    checkOutput("t1Hold", dutVec, packVec(3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 4'd2, 4'd2, 4'd2));

    // Alarm to 23:00, then hour and minute wraps
    applyStimulus(B_SET); press(B_INC, 23); applyStimulus(B_SET); applyStimulus(B_SET);
    checkOutput("t2AlmLoad", dutVec, packVec(3'd3, 1'b0, 1'b1, 1'b1, 1'b0, 2'd2, 4'd3, 4'd0, 4'd0));
    tick(1);
    applyStimulus(B_SET); press(B_INC, 2); applyStimulus(B_SET); press(B_INC, 60); applyStimulus(B_SET);
    checkOutput("t2WrapLoad", dutVec, packVec(3'd3, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 4'd1, 4'd0, 4'd0));
    tick(1);

    // Abort in minute edit
    setTime(7, 45);
    applyStimulus(B_MODE); applyStimulus(B_INC); applyStimulus(B_SET); applyStimulus(B_INC); applyStimulus(B_MODE);
    checkOutput("t3Abort", dutVec, packVec(3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 4'd1, 4'd0, 4'd0));
    tick(2);
    checkOutput("t3NoLoad", dutVec, packVec(3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 4'd1, 4'd0, 4'd0));

    // Arm 12:29, ring, stop, held alarm must not re-ring
    applyStimulus(B_SET); press(B_INC, 11); applyStimulus(B_SET); press(B_INC, 29); applyStimulus(B_SET);
    checkOutput("t4Arm", dutVec, packVec(3'd3, 1'b0, 1'b1, 1'b1, 1'b0, 2'd1, 4'd2, 4'd2, 4'd9));
    tick(1);
    setTime(12, 29); alarm = 1'b1; tick(1);
    checkOutput("t4Ring", dutVec, packVec(3'd4, 1'b0, 1'b0, 1'b1, 1'b1, 2'd1, 4'd2, 4'd2, 4'd9));
    applyStimulus(B_STOP);
    checkOutput("t4Stop", dutVec, packVec(3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd1, 4'd2, 4'd2, 4'd9));
    tick(5);
    checkOutput("t4NoRetrigger", dutVec, packVec(3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd1, 4'd2, 4'd2, 4'd9));
    alarm = 1'b0; tick(1);

    // Snooze across midnight, then restore on stop
    setTime(23, 57); alarm = 1'b1; tick(1);
    applyStimulus(B_SNZ);
    checkOutput("t5Snooze", dutVec, packVec(3'd3, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 4'd0, 4'd0, 4'd2));
    tick(1); alarm = 1'b0; tick(1); alarm = 1'b1; tick(1);
    applyStimulus(B_STOP);
    checkOutput("t5Restore", dutVec, packVec(3'd3, 1'b0, 1'b1, 1'b1, 1'b0, 2'd1, 4'd2, 4'd2, 4'd9));
    tick(1); alarm = 1'b0; tick(1);

    // Ring timeout length, then stop beats snooze
    alarm = 1'b1; ringLen = 0;
    for (int i = 0; i < RC + 10; i++) begin
      @(posedge clk); #1;
      if (buzzer) ringLen++;
    end
    checkOutput("t6RingLen", 21'(ringLen), 21'(RC));
    checkOutput("t6Idle", dutVec, packVec(3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd1, 4'd2, 4'd2, 4'd9));
    alarm = 1'b0; tick(1); alarm = 1'b1; tick(1);
    applyStimulus(B_STOP | B_SNZ);
    checkOutput("t6StopWins", dutVec, packVec(3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd1, 4'd2, 4'd2, 4'd9));
    alarm = 1'b0; tick(1);

    // Random traffic
    for (int i = 0; i < 4000; i++) begin
      btnMode   = ($urandom_range(0, 15) == 0);
      btnSet    = ($urandom_range(0, 9) == 0);
      btnInc    = ($urandom_range(0, 3) == 0);
      btnSnooze = ($urandom_range(0, 19) == 0);
      btnStop   = ($urandom_range(0, 19) == 0);
      reset     = ($urandom_range(0, 399) == 0);
      if ($urandom_range(0, 14) == 0) alarm = ~alarm;
      if ($urandom_range(0, 9) == 0) setTime(int'($urandom_range(0, 23)), int'($urandom_range(0, 59)));
      @(posedge clk); #1;
    end
    {btnStop, btnSnooze, btnInc, btnSet, btnMode} = 5'b0;
    reset = 1'b0;
    tick(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
